// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm buzzer slice.
package alarm_pkg;

  // Buzzer controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    SNOOZE   = 2'd3
  } buzz_state_t;

  // Largest of three durations; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_buzzer_tone_gen.sv
// Square-wave tone generator: toggles every HALF_PERIOD enabled cycles,
// starts low after clr, and is held low whenever it is not enabled.
module tone_gen #(
  parameter int HALF_PERIOD = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tone_o
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  // Half-period counter and toggle decision; clear/disable force a low restart.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr || !en) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Registered tone output; async reset drops it low immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/alarm_buzzer.sv
// Alarm buzzer: turns a trigger pulse into a cadenced beep pattern with
// snooze, stop and an automatic give-up after MAX_BEEPS on/off periods.
module alarm_buzzer
  import alarm_pkg::*;
#(
  parameter int TONE_HALF_PERIOD = 25000,
  parameter int BEEP_ON_CYCLES   = 12500000,
  parameter int BEEP_OFF_CYCLES  = 12500000,
  parameter int MAX_BEEPS        = 120,
  parameter int SNOOZE_CYCLES    = 500000000,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               trigger,
  input  logic                               btn_snooze,
  input  logic                               btn_stop,
  output logic                               speaker_out,
  output logic                               ringing,
  output logic                               snoozing,
  output logic                               timeout,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   snoozes_used
);

  localparam int PH_MAX = max3(BEEP_ON_CYCLES, BEEP_OFF_CYCLES, SNOOZE_CYCLES);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = $clog2(MAX_BEEPS + 1);
  localparam int SN_W   = $clog2(MAX_SNOOZES + 1);

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BEEP_ON_CYCLES - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(BEEP_OFF_CYCLES - 1);
  localparam logic [PH_W-1:0] SNZ_LAST = PH_W'(SNOOZE_CYCLES - 1);
  localparam logic [BC_W-1:0] BEEP_MAX = BC_W'(MAX_BEEPS);
  localparam logic [SN_W-1:0] SNZ_MAX  = SN_W'(MAX_SNOOZES);

  buzz_state_t      state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [BC_W-1:0]  beep_q, beep_d;
  logic [SN_W-1:0]  snz_q, snz_d;
  logic             timeout_q, timeout_d;
  logic [BC_W-1:0]  beep_inc;
  logic             tone_en, tone_clr;

  assign beep_inc = beep_q + 1'b1;

  // Next-state logic: stop beats snooze beats phase-timer expiry.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    beep_d    = beep_q;
    snz_d     = snz_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (trigger) begin
          state_d = BEEP_ON;
          beep_d  = '0;
          snz_d   = '0;
        end
      end
      BEEP_ON, BEEP_OFF: begin
        if (btn_stop) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (btn_snooze && (snz_q < SNZ_MAX)) begin
          state_d = SNOOZE;
          snz_d   = snz_q + 1'b1;
          phase_d = '0;
        end else if (state_q == BEEP_ON && phase_q == ON_LAST) begin
          state_d = BEEP_OFF;
          phase_d = '0;
        end else if (state_q == BEEP_OFF && phase_q == OFF_LAST) begin
          beep_d  = beep_inc;
          phase_d = '0;
          if (beep_inc == BEEP_MAX) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            state_d = BEEP_ON;
          end
        end
      end
      SNOOZE: begin
        if (btn_stop) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (phase_q == SNZ_LAST) begin
          state_d = BEEP_ON;
          beep_d  = '0;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      beep_q    <= '0;
      snz_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      beep_q    <= beep_d;
      snz_q     <= snz_d;
      timeout_q <= timeout_d;
    end
  end

  // The tone register follows the state being entered, so the speaker is
  // low on the very cycle a burst ends and starts low on every burst entry.
  assign tone_en  = (state_d == BEEP_ON);
  assign tone_clr = (state_d == BEEP_ON) && (state_q != BEEP_ON);

  tone_gen #(
    .HALF_PERIOD(TONE_HALF_PERIOD)
  ) u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (tone_en),
    .clr   (tone_clr),
    .tone_o(speaker_out)
  );

  assign ringing      = (state_q == BEEP_ON) || (state_q == BEEP_OFF);
  assign snoozing     = (state_q == SNOOZE);
  assign timeout      = timeout_q;
  assign snoozes_used = snz_q;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Bench for alarm_buzzer: cadence model checked every cycle plus directed
// literal expectations for the basic ring, stop, snooze and corner cases.
module tb_alarm_buzzer;

  localparam int HP   = 2;
  localparam int ON   = 8;
  localparam int OFF  = 4;
  localparam int MAXB = 3;
  localparam int SNZ  = 20;
  localparam int MAXS = 2;
  localparam int P    = ON + OFF;
  localparam int SW   = $clog2(MAXS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trigger = 1'b0;
  logic          btn_snooze = 1'b0;
  logic          btn_stop = 1'b0;
  logic          speaker_out, ringing, snoozing, timeout;
  logic [SW-1:0] snoozes_used;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alarm_buzzer #(
    .TONE_HALF_PERIOD(HP),
    .BEEP_ON_CYCLES  (ON),
    .BEEP_OFF_CYCLES (OFF),
    .MAX_BEEPS       (MAXB),
    .SNOOZE_CYCLES   (SNZ),
    .MAX_SNOOZES     (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .btn_snooze  (btn_snooze),
    .btn_stop    (btn_stop),
    .speaker_out (speaker_out),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .timeout     (timeout),
    .snoozes_used(snoozes_used)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cadence model: mode 0 idle, 1 ringing, 2 snoozing. Ringing time is kept
  // as an offset from the start of the current ring window.
  int mcyc = 0;
  int m_mode = 0;
  int ring_start = 0;
  int snz_start = 0;
  int m_used = 0;
  bit m_to = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcyc <= 0; m_mode <= 0; ring_start <= 0; snz_start <= 0; m_used <= 0; m_to <= 1'b0;
    end else begin
      mcyc <= mcyc + 1;
      m_to <= 1'b0;
      case (m_mode)
        0: if (trigger) begin
             m_mode <= 1; ring_start <= mcyc + 1; m_used <= 0;
           end
        1: if (btn_stop) m_mode <= 0;
           else if (btn_snooze && m_used < MAXS) begin
             m_mode <= 2; snz_start <= mcyc + 1; m_used <= m_used + 1;
           end else if (mcyc - ring_start == MAXB * P - 1) begin
             m_mode <= 0; m_to <= 1'b1;
           end
        default: if (btn_stop) m_mode <= 0;
           else if (mcyc - snz_start == SNZ - 1) begin
             m_mode <= 1; ring_start <= mcyc + 1;
           end
      endcase
    end
  end

  function automatic bit exp_spk();
    int k;
    if (m_mode != 1) return 1'b0;
    k = (mcyc - ring_start) % P;
    return (k < ON) && (((k / HP) % 2) == 1);
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_ringing", ringing, (m_mode == 1));
      chk("model_snoozing", snoozing, (m_mode == 2));
      chk("model_speaker", speaker_out, exp_spk());
      chk("model_timeout", timeout, m_to);
      chk("model_snoozes_used", snoozes_used, m_used);
    end
  end

  int rel = 0;
  int to_cnt = 0;

  task automatic nxt();
    @(negedge clk);
    rel++;
    trigger = 1'b0; btn_snooze = 1'b0; btn_stop = 1'b0;
    to_cnt += int'(timeout);
  endtask

  task automatic go(input int target);
    while (rel < target) nxt();
  endtask

  task automatic start();
    @(negedge clk);
    trigger = 1'b1;
    rel = 0;
    to_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_speaker", speaker_out, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_snoozes_used", snoozes_used, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic ring and timeout
    start();
    go(1);  chk("basic_ringing_c1", ringing, 1);
    go(2);  chk("basic_spk_c2", speaker_out, 0);
    go(3);  chk("basic_spk_c3", speaker_out, 1);
    go(4);  chk("basic_spk_c4", speaker_out, 1);
    go(5);  chk("basic_spk_c5", speaker_out, 0);
    go(7);  chk("basic_spk_c7", speaker_out, 1);
    go(8);  chk("basic_spk_c8", speaker_out, 1);
    go(9);  chk("basic_spk_c9", speaker_out, 0); chk("basic_ring_c9", ringing, 1);
    go(12); chk("basic_spk_c12", speaker_out, 0); chk("basic_ring_c12", ringing, 1);
    go(13); chk("basic_ring_c13", ringing, 1);
    go(15); chk("basic_spk_c15", speaker_out, 1);
    go(36); chk("basic_ring_c36", ringing, 1); chk("basic_to_c36", timeout, 0);
    go(37); chk("basic_to_c37", timeout, 1); chk("basic_ring_c37", ringing, 0);
    go(45); chk("basic_to_count", to_cnt, 1);

    // Stop during second burst
    start();
    go(14); btn_stop = 1'b1;
    go(15); chk("stop_ring", ringing, 0); chk("stop_spk", speaker_out, 0);
    go(60); chk("stop_no_timeout", to_cnt, 0);

    // Snooze then resume with a fresh timeout window
    start();
    go(4);  btn_snooze = 1'b1;
    go(5);  chk("snz_snoozing_c5", snoozing, 1); chk("snz_used_c5", snoozes_used, 1);
            chk("snz_ring_c5", ringing, 0);
    go(24); chk("snz_snoozing_c24", snoozing, 1);
    go(25); chk("snz_ring_c25", ringing, 1); chk("snz_snoozing_c25", snoozing, 0);
    go(27); chk("snz_spk_c27", speaker_out, 1);
    go(60); chk("snz_to_c60", timeout, 0);
    go(61); chk("snz_to_c61", timeout, 1); chk("snz_ring_c61", ringing, 0);
    go(64);

    // Snooze limit
    start();
    go(2);  btn_snooze = 1'b1;
    go(3);  chk("lim_snoozing_1", snoozing, 1);
    go(23); chk("lim_ring_1", ringing, 1);
    go(25); btn_snooze = 1'b1;
    go(26); chk("lim_snoozing_2", snoozing, 1); chk("lim_used_2", snoozes_used, 2);
    go(46); chk("lim_ring_2", ringing, 1);
    go(48); btn_snooze = 1'b1;
    go(49); chk("lim_ignored_ring", ringing, 1); chk("lim_ignored_snz", snoozing, 0);
            chk("lim_used_stays", snoozes_used, 2);
    go(50); btn_stop = 1'b1;
    go(52); chk("lim_stop_ring", ringing, 0); chk("lim_used_kept", snoozes_used, 2);

    // Trigger while ringing, then stop and snooze together
    start();
    go(4);  trigger = 1'b1;
    go(7);  chk("retrig_spk_c7", speaker_out, 1);
    go(9);  chk("retrig_spk_c9", speaker_out, 0); chk("retrig_ring_c9", ringing, 1);
    go(13); chk("retrig_ring_c13", ringing, 1);
    go(15); chk("retrig_spk_c15", speaker_out, 1);
    go(16); btn_stop = 1'b1; btn_snooze = 1'b1;
    go(17); chk("both_ring", ringing, 0); chk("both_snoozing", snoozing, 0);
            chk("both_used", snoozes_used, 0);
    go(20);

    // Asynchronous reset mid-burst
    start();
    go(3);  chk("areset_spk_before", speaker_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_spk", speaker_out, 0);
    chk("areset_ring", ringing, 0);
    chk("areset_snoozing", snoozing, 0);
    chk("areset_timeout", timeout, 0);
    chk("areset_used", snoozes_used, 0);
    @(negedge clk);
    reset = 1'b0;
    go(rel + 3);
    chk("areset_idle_after", ringing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer.md
Name: alarm_buzzer

Overview:
Consumer of the alarm FSM's one-cycle trigger pulse; converts it into an audible cadenced beep pattern on the speaker pin. Handles user snooze and stop buttons and an automatic give-up timeout. Sits between the alarm-setting FSM (trigger source) and the board speaker pin.

Parameters:
TONE_HALF_PERIOD, 25000, clk cycles per half period of the square-wave tone (1 kHz at 50 MHz)
BEEP_ON_CYCLES, 12500000, clk cycles of each audible burst
BEEP_OFF_CYCLES, 12500000, clk cycles of silence between bursts
MAX_BEEPS, 120, completed on/off periods before automatic timeout
SNOOZE_CYCLES, 500000000, clk cycles spent silent in snooze
MAX_SNOOZES, 3, snoozes allowed per alarm event

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
trigger  in  1  one-cycle pulse from alarm FSM, starts ringing
btn_snooze  in  1  debounced one-cycle pulse
btn_stop  in  1  debounced one-cycle pulse
speaker_out  out  1  square-wave drive, registered
ringing  out  1  high in BEEP_ON or BEEP_OFF
snoozing  out  1  high in SNOOZE
timeout  out  1  one-cycle pulse when MAX_BEEPS exhausted
snoozes_used  out  $clog2(MAX_SNOOZES+1)  snoozes taken this event

Behaviour:
- Reset, clk: reset asynchronous, active-high; clock clk. Reset forces IDLE; all counters 0; speaker_out=0, timeout=0, snoozes_used=0. ringing/snoozing decode from registered state, so they are 0 in reset.
- States: IDLE, BEEP_ON, BEEP_OFF, SNOOZE.
- IDLE: speaker_out=0. trigger -> BEEP_ON next cycle; beep_cnt=0, snoozes_used=0, phase_cnt=0, tone_cnt=0. btn_snooze/btn_stop ignored.
- BEEP_ON: lasts exactly BEEP_ON_CYCLES cycles (phase_cnt 0..BEEP_ON_CYCLES-1). speaker_out is 0 on entry and toggles when tone_cnt==TONE_HALF_PERIOD-1, at which point tone_cnt wraps to 0. First rising edge occurs TONE_HALF_PERIOD cycles after entry. At end -> BEEP_OFF, with speaker_out forced 0 in the same cycle.
- BEEP_OFF: lasts exactly BEEP_OFF_CYCLES cycles, speaker_out=0. At end, beep_cnt increments.
  - If the new count == MAX_BEEPS -> IDLE, and timeout pulses for one cycle coincident with the IDLE entry.
  - Otherwise -> BEEP_ON, with phase_cnt and tone_cnt cleared.
- SNOOZE: speaker_out=0 for exactly SNOOZE_CYCLES cycles, then -> BEEP_ON with beep_cnt=0 (fresh timeout window); snoozes_used is kept.
- btn_stop in BEEP_ON/BEEP_OFF/SNOOZE -> IDLE next cycle; speaker_out=0; no timeout pulse.
- btn_snooze in BEEP_ON/BEEP_OFF:
  - If snoozes_used < MAX_SNOOZES -> SNOOZE, snoozes_used+1, phase_cnt=0.
  - Otherwise ignored; ringing continues uninterrupted.
- btn_snooze in SNOOZE: ignored; the snooze timer is not restarted.
- Priority in one cycle: btn_stop > btn_snooze > phase timer expiry.
- trigger while not IDLE: ignored; no restart, counters untouched.
- trigger and btn_stop in the same IDLE cycle: trigger wins.
- Counter widths are $clog2(max+1) of the relevant parameter. No counter may wrap past its terminal value.
- Asynchronous reset mid-ring: speaker_out goes 0 immediately, with no glitch beyond the reset edge.

Decomposition:
- Shared package alarm_pkg: enum buzz_state_t {IDLE, BEEP_ON, BEEP_OFF, SNOOZE}, 2-bit encoding.
- One sub-module, tone_gen:
  - Inputs: clk, reset, en, clr.
  - Output: registered square wave, parameter HALF_PERIOD.
  - en is high only in BEEP_ON; clr fires on every BEEP_ON entry.
  - Output is held at 0 when en=0.
- The FSM, phase counter, beep counter and snooze counter live in alarm_buzzer.

Test Plan:
All scenarios use TONE_HALF_PERIOD=2, BEEP_ON=8, BEEP_OFF=4, MAX_BEEPS=3, SNOOZE=20, MAX_SNOOZES=2.
- Basic ring: trigger pulse at cycle 0.
  - ringing=1 from cycle 1.
  - speaker_out rises at cycle 3, toggles every 2 cycles, and is 0 for cycles 9-12.
  - Second burst starts at cycle 13.
- Timeout: trigger, no buttons.
  - Three 12-cycle periods complete.
  - timeout pulses exactly once at cycle 37, where ringing=0 and the state is IDLE.
- Stop: btn_stop during the second BEEP_ON -> next cycle ringing=0, speaker_out=0, no timeout pulse ever.
- Snooze: btn_snooze at cycle 4.
  - snoozing=1 for cycles 5-24 and snoozes_used=1.
  - BEEP_ON resumes at cycle 25 with beep_cnt reset.
  - timeout arrives 36 cycles after the resume.
- Snooze limit: snooze twice, then a third btn_snooze while ringing -> ignored; ringing stays 1 and snoozes_used stays 2.
- Corner cases:
  - trigger while ringing -> no restart; the cadence phase is unchanged.
  - btn_stop and btn_snooze in the same cycle -> IDLE.
  - Reset asserted mid-BEEP_ON -> all outputs 0 asynchronously.
